prco_sequencer: RTL and testbench
=================================

// Module: prco_sequencer
// PURPOSE
//  Multi-cycle control FSM for the PRCO core: steps each instruction through FETCH, DECODE,
//  EXEC, MEM and WB, and issues one-cycle enable pulses to the fetch unit, decoder, ALU, LSU
//  and register-file write port. Owns the program counter: increments it or loads a jump
//  target. Times out stalled handshakes into a sticky FAULT state.
// PARAMETERS
//  PC_RESET   16'h0000  PC value loaded on reset
//  TIMEOUT_W  4         wait-counter width; fault after 2**TIMEOUT_W-1 cycles with no handshake
// PORTS
//  i_clk          in   1   core clock
//  i_reset        in   1   asynchronous, active-high reset
//  i_en           in   1   run enable; sampled in IDLE and WB only
//  q_fetch_ce     out  1   1-cycle pulse: fetch the instruction at q_pc
//  i_fetch_valid  in   1   fetched instruction word presented to the decoder
//  q_dec_ce       out  1   1-cycle pulse: decoder latches the instruction
//  i_dec_ce       in   1   decoder: instruction needs execution
//  i_dec_fetch    in   1   decoder: NOP/unknown, skip to the next fetch
//  i_reg_we       in   1   decoder: instruction writes Rd
//  i_req_ram      in   1   decoder: instruction needs the memory stage
//  i_req_ram_we   in   1   decoder: memory access is a store
//  q_alu_ce       out  1   1-cycle pulse: start the ALU
//  i_alu_done     in   1   ALU result valid
//  i_jmp_taken    in   1   jump resolved taken; sampled with i_alu_done
//  i_jmp_addr     in   16  jump target; sampled with i_alu_done
//  q_mem_ce       out  1   1-cycle pulse: start the RAM access
//  q_mem_we       out  1   store qualifier; held for the whole MEM state
//  i_mem_ack      in   1   RAM access complete
//  q_reg_we       out  1   1-cycle register-file write strobe in WB
//  q_pc           out  16  program counter
//  q_state        out  3   current FSM state (debug)
//  q_fault        out  1   sticky handshake-timeout flag
// BEHAVIOUR
//  Reset (async, any state, mid-instruction included):
//   - state=IDLE, q_pc=PC_RESET.
//   - All other outputs, the latched request flags and the wait counter cleared.
//  States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 FAULT=7. All outputs are registered.
//  Enable pulses: each *_ce is high only in the first cycle of its state.
//  IDLE:   i_en=1 -> FETCH (next cycle).
//  FETCH:  i_fetch_valid -> DECODE.
//  DECODE: if i_dec_fetch:
//           - q_pc<=q_pc+1 -> FETCH.
//           - i_dec_fetch wins when i_dec_ce is asserted in the same cycle.
//          elif i_dec_ce:
//           - latch i_reg_we, i_req_ram, i_req_ram_we -> EXEC.
//  EXEC:   on i_alu_done:
//           - latch i_jmp_taken and i_jmp_addr.
//           - req_ram -> MEM, else -> WB.
//  MEM:    q_mem_we=latched req_ram_we throughout the state; i_mem_ack -> WB.
//  WB:     single cycle.
//           - q_reg_we=latched reg_we.
//           - q_pc<=jmp_taken ? jmp_addr : q_pc+1.
//           - i_en=1 -> FETCH, else -> IDLE.
//           - i_en deasserted mid-instruction: the instruction still completes; the FSM stops in WB->IDLE.
//  PC arithmetic: 16-bit, wraps 16'hFFFF+1 -> 16'h0000.
//  Wait counter:
//   - Cleared on every state entry; increments each cycle in FETCH, DECODE, EXEC and MEM
//     while the awaited handshake is low.
//   - Reaching all-ones -> FAULT.
//   - A handshake arriving in the same cycle as the all-ones count wins (normal transition).
//  FAULT: all pulses low, q_fault=1, q_pc frozen; exit by reset only.
//  Handshake inputs arriving outside their own state are ignored.
// STRUCTURE
//  - State encodings PRCO_SEQ_* go in inc/prco_constants.v, next to the existing constants.
//  - Sub-module prco_seq_timeout: loadable wait counter with clear, enable and q_expired;
//    parameter TIMEOUT_W.
//  - The FSM, PC and latched flags stay in prco_sequencer.
// TESTING
//  1 MOVI: reset, i_en=1; fetch_valid at +1; dec_ce (reg_we=1); alu_done at +1
//     -> q_reg_we one cycle, q_pc 0->1, back to FETCH.
//  2 LW then SW: req_ram=1, we=0 then 1; mem_ack after 3 cycles
//     -> q_mem_ce pulse, q_mem_we 0 then 1 held for all of MEM, q_reg_we only for LW.
//  3 NOP: i_dec_fetch=1 together with i_dec_ce=1
//     -> no q_alu_ce, q_pc+1, FETCH on the next cycle.
//  4 JMP: i_jmp_taken=1, i_jmp_addr=16'h0040 with alu_done
//     -> q_pc=16'h0040 after WB; q_pc=16'hFFFF with no jump -> 16'h0000.
//  5 Timeout: TIMEOUT_W=4, fetch_valid held low
//     -> FAULT after 15 cycles, q_fault=1; stays there with i_en=1; i_reset clears it.
//  6 i_en dropped in EXEC -> instruction completes WB, then IDLE; async reset asserted
//     in MEM -> immediate IDLE, q_pc=PC_RESET, all outputs 0.

Source files
------------

// File: rtl/prco_sequencer_pkg.sv
// prco_sequencer_pkg: state encodings, latched request flags and PC helper for the PRCO sequencer
package prco_sequencer_pkg;

    localparam logic [2:0] PRCO_SEQ_IDLE   = 3'd0;
    localparam logic [2:0] PRCO_SEQ_FETCH  = 3'd1;
    localparam logic [2:0] PRCO_SEQ_DECODE = 3'd2;
    localparam logic [2:0] PRCO_SEQ_EXEC   = 3'd3;
    localparam logic [2:0] PRCO_SEQ_MEM    = 3'd4;
    localparam logic [2:0] PRCO_SEQ_WB     = 3'd5;
    localparam logic [2:0] PRCO_SEQ_FAULT  = 3'd7;

    typedef struct packed {
        logic reg_we;
        logic req_ram;
        logic req_ram_we;
    } prco_req_t;

    function automatic logic [15:0] prco_pc_inc(input logic [15:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/prco_seq_timeout.sv
// prco_seq_timeout: handshake wait counter, cleared on state entry, expires at all-ones
module prco_seq_timeout #(
    parameter int TIMEOUT_W = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_en,
    output logic q_expired
);

    logic [TIMEOUT_W-1:0] r_count;

    // count waiting cycles; clear takes priority so every state starts from zero
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + 1'b1;
    end

    assign q_expired = &r_count;

endmodule

// File: rtl/prco_sequencer.sv
// prco_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with PC and handshake timeout
module prco_sequencer
    import prco_sequencer_pkg::*;
#(
    parameter logic [15:0] PC_RESET  = 16'h0000,
    parameter int          TIMEOUT_W = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    output logic        q_fetch_ce,
    input  logic        i_fetch_valid,
    output logic        q_dec_ce,
    input  logic        i_dec_ce,
    input  logic        i_dec_fetch,
    input  logic        i_reg_we,
    input  logic        i_req_ram,
    input  logic        i_req_ram_we,
    output logic        q_alu_ce,
    input  logic        i_alu_done,
    input  logic        i_jmp_taken,
    input  logic [15:0] i_jmp_addr,
    output logic        q_mem_ce,
    output logic        q_mem_we,
    input  logic        i_mem_ack,
    output logic        q_reg_we,
    output logic [15:0] q_pc,
    output logic [2:0]  q_state,
    output logic        q_fault
);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        w_hs;
    logic        w_wait;
    logic        w_enter;
    logic        w_expired;
    prco_req_t   r_req;
    logic        r_jmp_taken;
    logic [15:0] r_jmp_addr;
    logic [15:0] r_pc;
    logic        r_fetch_ce;
    logic        r_dec_ce;
    logic        r_alu_ce;
    logic        r_mem_ce;
    logic        r_mem_we;
    logic        r_reg_we;
    logic        r_fault;

    // the handshake each waiting state is blocked on; anything else is ignored
    always_comb begin
        w_hs = r_state == PRCO_SEQ_FETCH  ? i_fetch_valid :
               r_state == PRCO_SEQ_DECODE ? (i_dec_fetch | i_dec_ce) :
               r_state == PRCO_SEQ_EXEC   ? i_alu_done :
               r_state == PRCO_SEQ_MEM    ? i_mem_ack : 1'b0;
        w_wait = r_state inside {PRCO_SEQ_FETCH, PRCO_SEQ_DECODE, PRCO_SEQ_EXEC, PRCO_SEQ_MEM};
        w_enter = w_next != r_state;
    end

    // next state; a handshake in the expiry cycle still takes the normal path
    always_comb begin
        w_next = r_state;
        case (r_state)
            PRCO_SEQ_IDLE:   w_next = i_en ? PRCO_SEQ_FETCH : PRCO_SEQ_IDLE;
            PRCO_SEQ_FETCH:  w_next = i_fetch_valid ? PRCO_SEQ_DECODE :
                                      w_expired ? PRCO_SEQ_FAULT : PRCO_SEQ_FETCH;
            PRCO_SEQ_DECODE: w_next = i_dec_fetch ? PRCO_SEQ_FETCH :
                                      i_dec_ce ? PRCO_SEQ_EXEC :
                                      w_expired ? PRCO_SEQ_FAULT : PRCO_SEQ_DECODE;
            PRCO_SEQ_EXEC:   w_next = i_alu_done ? (r_req.req_ram ? PRCO_SEQ_MEM : PRCO_SEQ_WB) :
                                      w_expired ? PRCO_SEQ_FAULT : PRCO_SEQ_EXEC;
            PRCO_SEQ_MEM:    w_next = i_mem_ack ? PRCO_SEQ_WB :
                                      w_expired ? PRCO_SEQ_FAULT : PRCO_SEQ_MEM;
            PRCO_SEQ_WB:     w_next = i_en ? PRCO_SEQ_FETCH : PRCO_SEQ_IDLE;
            PRCO_SEQ_FAULT:  w_next = PRCO_SEQ_FAULT;
            default:         w_next = PRCO_SEQ_IDLE;
        endcase
    end

    prco_seq_timeout #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_enter),
        .i_en      (w_wait & ~w_hs),
        .q_expired (w_expired)
    );

    // state and registered outputs; pulses fire only on entry into their state
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= PRCO_SEQ_IDLE;
            r_fetch_ce <= 1'b0;
            r_dec_ce   <= 1'b0;
            r_alu_ce   <= 1'b0;
            r_mem_ce   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_reg_we   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_fetch_ce <= w_enter && w_next == PRCO_SEQ_FETCH;
            r_dec_ce   <= w_enter && w_next == PRCO_SEQ_DECODE;
            r_alu_ce   <= w_enter && w_next == PRCO_SEQ_EXEC;
            r_mem_ce   <= w_enter && w_next == PRCO_SEQ_MEM;
            r_mem_we   <= w_next == PRCO_SEQ_MEM ? r_req.req_ram_we : 1'b0;
            r_reg_we   <= w_enter && w_next == PRCO_SEQ_WB && r_req.reg_we;
            r_fault    <= w_next == PRCO_SEQ_FAULT;
        end
    end

    // capture decoder request flags and the resolved jump for later stages
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_req       <= '0;
            r_jmp_taken <= 1'b0;
            r_jmp_addr  <= '0;
        end else begin
            if (r_state == PRCO_SEQ_DECODE && !i_dec_fetch && i_dec_ce)
                r_req <= '{reg_we: i_reg_we, req_ram: i_req_ram, req_ram_we: i_req_ram_we};
            if (r_state == PRCO_SEQ_EXEC && i_alu_done) begin
                r_jmp_taken <= i_jmp_taken;
                r_jmp_addr  <= i_jmp_addr;
            end
        end
    end

    // program counter: skip past NOPs in DECODE, advance or jump in WB
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_pc <= PC_RESET;
        else if (r_state == PRCO_SEQ_DECODE && i_dec_fetch)
            r_pc <= prco_pc_inc(r_pc);
        else if (r_state == PRCO_SEQ_WB)
            r_pc <= r_jmp_taken ? r_jmp_addr : prco_pc_inc(r_pc);
    end

    assign q_fetch_ce = r_fetch_ce;
    assign q_dec_ce   = r_dec_ce;
    assign q_alu_ce   = r_alu_ce;
    assign q_mem_ce   = r_mem_ce;
    assign q_mem_we   = r_mem_we;
    assign q_reg_we   = r_reg_we;
    assign q_pc       = r_pc;
    assign q_state    = r_state;
    assign q_fault    = r_fault;

endmodule

// File: tb/tb_prco_sequencer.sv
// tb_prco_sequencer: directed self-checking bench for the PRCO sequencer
module tb_prco_sequencer;

    logic        i_clk;
    logic        i_reset;
    logic        i_en;
    logic        q_fetch_ce;
    logic        i_fetch_valid;
    logic        q_dec_ce;
    logic        i_dec_ce;
    logic        i_dec_fetch;
    logic        i_reg_we;
    logic        i_req_ram;
    logic        i_req_ram_we;
    logic        q_alu_ce;
    logic        i_alu_done;
    logic        i_jmp_taken;
    logic [15:0] i_jmp_addr;
    logic        q_mem_ce;
    logic        q_mem_we;
    logic        i_mem_ack;
    logic        q_reg_we;
    logic [15:0] q_pc;
    logic [2:0]  q_state;
    logic        q_fault;

    int n_cmp = 0;
    int n_bad = 0;

    prco_sequencer #(
        .PC_RESET  (16'h0000),
        .TIMEOUT_W (4)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_en          (i_en),
        .q_fetch_ce    (q_fetch_ce),
        .i_fetch_valid (i_fetch_valid),
        .q_dec_ce      (q_dec_ce),
        .i_dec_ce      (i_dec_ce),
        .i_dec_fetch   (i_dec_fetch),
        .i_reg_we      (i_reg_we),
        .i_req_ram     (i_req_ram),
        .i_req_ram_we  (i_req_ram_we),
        .q_alu_ce      (q_alu_ce),
        .i_alu_done    (i_alu_done),
        .i_jmp_taken   (i_jmp_taken),
        .i_jmp_addr    (i_jmp_addr),
        .q_mem_ce      (q_mem_ce),
        .q_mem_we      (q_mem_we),
        .i_mem_ack     (i_mem_ack),
        .q_reg_we      (q_reg_we),
        .q_pc          (q_pc),
        .q_state       (q_state),
        .q_fault       (q_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        i_fetch_valid = 0; i_dec_ce = 0; i_dec_fetch = 0; i_reg_we = 0;
        i_req_ram = 0; i_req_ram_we = 0; i_alu_done = 0; i_jmp_taken = 0;
        i_jmp_addr = 16'h0; i_mem_ack = 0;
    endtask

    // one full instruction starting at the negedge just after FETCH entry
    task automatic do_instr(input logic rw, input logic rr, input logic rwe, input logic jt,
                            input logic [15:0] ja, input int mw,
                            input logic [15:0] pc0, input logic [15:0] pc1);
        check("fetch_state", q_state, 1);
        check("fetch_ce", q_fetch_ce, 1);
        check("pc_before", q_pc, pc0);
        i_fetch_valid = 1;
        cyc();
        check("dec_state", q_state, 2);
        check("dec_ce", q_dec_ce, 1);
        check("fetch_ce_low", q_fetch_ce, 0);
        i_fetch_valid = 0; i_dec_ce = 1; i_reg_we = rw; i_req_ram = rr; i_req_ram_we = rwe;
        cyc();
        check("exec_state", q_state, 3);
        check("alu_ce", q_alu_ce, 1);
        check("dec_ce_low", q_dec_ce, 0);
        i_dec_ce = 0; i_reg_we = 0; i_req_ram = 0; i_req_ram_we = 0;
        i_alu_done = 1; i_jmp_taken = jt; i_jmp_addr = ja;
        cyc();
        i_alu_done = 0; i_jmp_taken = 0; i_jmp_addr = 16'h0;
        if (rr) begin
            check("mem_state", q_state, 4);
            check("mem_ce", q_mem_ce, 1);
            check("mem_we", q_mem_we, rwe);
            for (int i = 1; i < mw; i++) begin
                cyc();
                check("mem_hold_state", q_state, 4);
                check("mem_ce_low", q_mem_ce, 0);
                check("mem_we_hold", q_mem_we, rwe);
            end
            i_mem_ack = 1;
            cyc();
            i_mem_ack = 0;
        end
        check("wb_state", q_state, 5);
        check("wb_reg_we", q_reg_we, rw);
        check("wb_mem_we", q_mem_we, 0);
        check("wb_pc", q_pc, pc0);
        cyc();
        check("next_state", q_state, 1);
        check("next_fetch_ce", q_fetch_ce, 1);
        check("pc_after", q_pc, pc1);
        check("reg_we_low", q_reg_we, 0);
    endtask

    initial begin
        i_reset = 1; i_en = 0;
        clear_inputs();
        cyc();
        cyc();
        i_reset = 0;
        cyc();
        check("rst_state", q_state, 0);
        check("rst_pc", q_pc, 16'h0000);
        check("rst_fault", q_fault, 0);
        check("rst_fetch_ce", q_fetch_ce, 0);
        check("rst_reg_we", q_reg_we, 0);
        check("idle_hold", q_state, 0);
        i_en = 1;
        cyc();
        // MOVI, LW, SW, taken jump, jump to top, wrap to zero
        do_instr(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0001);
        do_instr(1, 1, 0, 0, 16'h0000, 3, 16'h0001, 16'h0002);
        do_instr(0, 1, 1, 0, 16'h0000, 3, 16'h0002, 16'h0003);
        do_instr(0, 0, 0, 1, 16'h0040, 0, 16'h0003, 16'h0040);
        do_instr(0, 0, 0, 1, 16'hFFFF, 0, 16'h0040, 16'hFFFF);
        do_instr(1, 0, 0, 0, 16'h0000, 0, 16'hFFFF, 16'h0000);
        // NOP with dec_ce also asserted: dec_fetch wins
        i_fetch_valid = 1;
        cyc();
        check("nop_dec_state", q_state, 2);
        i_fetch_valid = 0; i_dec_fetch = 1; i_dec_ce = 1; i_reg_we = 1;
        cyc();
        clear_inputs();
        check("nop_state", q_state, 1);
        check("nop_fetch_ce", q_fetch_ce, 1);
        check("nop_alu_ce", q_alu_ce, 0);
        check("nop_pc", q_pc, 16'h0001);
        // enable dropped in EXEC: finish WB then stop in IDLE
        i_fetch_valid = 1;
        cyc();
        i_fetch_valid = 0; i_dec_ce = 1; i_reg_we = 1;
        cyc();
        clear_inputs();
        i_en = 0;
        cyc();
        check("en_drop_exec", q_state, 3);
        i_alu_done = 1;
        cyc();
        i_alu_done = 0;
        check("en_drop_wb", q_state, 5);
        check("en_drop_reg_we", q_reg_we, 1);
        cyc();
        check("en_drop_idle", q_state, 0);
        check("en_drop_pc", q_pc, 16'h0002);
        check("en_drop_fetch_ce", q_fetch_ce, 0);
        cyc();
        check("en_drop_idle_hold", q_state, 0);
        // async reset in the middle of a store
        i_en = 1;
        cyc();
        check("st_fetch", q_state, 1);
        check("st_pc", q_pc, 16'h0002);
        i_fetch_valid = 1;
        cyc();
        i_fetch_valid = 0; i_dec_ce = 1; i_req_ram = 1; i_req_ram_we = 1;
        cyc();
        clear_inputs();
        i_alu_done = 1;
        cyc();
        i_alu_done = 0;
        check("st_mem_state", q_state, 4);
        check("st_mem_we", q_mem_we, 1);
        #2 i_reset = 1;
        #1;
        check("arst_state", q_state, 0);
        check("arst_pc", q_pc, 16'h0000);
        check("arst_mem_we", q_mem_we, 0);
        check("arst_mem_ce", q_mem_ce, 0);
        i_en = 0;
        cyc();
        i_reset = 0;
        cyc();
        check("arst_idle_hold", q_state, 0);
        // handshake on the expiry cycle wins, then timeout in DECODE
        i_en = 1;
        cyc();
        repeat (15) cyc();
        check("fetch_at_limit", q_state, 1);
        i_fetch_valid = 1;
        cyc();
        i_fetch_valid = 0;
        check("limit_hs_wins", q_state, 2);
        check("limit_no_fault", q_fault, 0);
        repeat (15) cyc();
        check("dec_at_limit", q_state, 2);
        cyc();
        check("dec_timeout_state", q_state, 7);
        check("dec_timeout_fault", q_fault, 1);
        // FAULT ignores all handshakes and enable
        i_fetch_valid = 1; i_dec_ce = 1; i_alu_done = 1; i_mem_ack = 1;
        repeat (5) cyc();
        check("fault_sticky", q_state, 7);
        check("fault_flag", q_fault, 1);
        check("fault_pc", q_pc, 16'h0000);
        check("fault_fetch_ce", q_fetch_ce, 0);
        clear_inputs();
        i_reset = 1;
        cyc();
        i_reset = 0;
        cyc();
        // FETCH timeout with fetch_valid held low
        check("fetch_to_start", q_state, 1);
        repeat (15) cyc();
        check("fetch_to_limit", q_state, 1);
        cyc();
        check("fetch_to_state", q_state, 7);
        check("fetch_to_fault", q_fault, 1);
        #2 i_reset = 1;
        #1;
        check("fault_clr_state", q_state, 0);
        check("fault_clr_flag", q_fault, 0);
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
